// File: rtl/keypad_calc_core.sv
// keypad_calc_core: keypad scan/debounce, hex entry, register bank and registered ALU; define ALU_ACCUM_EN to make op 7 accumulate
module keypad_calc_core #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [3:0]       row_in,
  output logic [1:0]       col_sel,
  input  logic             commit,
  input  logic [AW-1:0]    addr_wr,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic [2:0]       op,
  output logic             key_valid,
  output logic [3:0]       key_code,
  output logic [WIDTH-1:0] entry,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {SCAN, DEB, PRESS, REL} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] row_m, row_s, code, cur_code;
  logic [1:0] row_idx;
  logic tick, hit, cnt_end, col_inc, cap;
  logic [WIDTH-1:0] bank [NREGS];
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0] alu;
  logic [WIDTH+3:0] shifted;
  assign tick = div == DW'(SCAN_DIV - 1);
  assign hit = |row_s;
  assign row_idx = row_s[0] ? 2'd0 : row_s[1] ? 2'd1 : row_s[2] ? 2'd2 : 2'd3;
  assign cur_code = {col_sel, row_idx};
  assign cnt_end = cnt == CW'(DEBOUNCE - 1);
  assign key_valid = state == PRESS;
  assign shifted = {entry, key_code};
  assign a = bank[addr_a];
  assign b = bank[addr_b];
  // Two-flop row synchroniser and scan tick divider
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_m <= '0;
      row_s <= '0;
      div <= '0;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
      div <= tick ? '0 : div + 1'b1;
    end
  // Scanner next state: advances only on ticks, except the one-cycle PRESS
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    col_inc = 1'b0;
    cap = 1'b0;
    case (state)
      SCAN: if (tick) begin
        col_inc = !hit;
        cap = hit;
        cnt_nx = hit ? CW'(1) : cnt;
        state_nx = !hit ? SCAN : (DEBOUNCE == 1) ? PRESS : DEB;
      end
      DEB: if (tick) begin
        cnt_nx = cnt + 1'b1;
        state_nx = !(hit && cur_code == code) ? SCAN : cnt_end ? PRESS : DEB;
      end
      PRESS: begin
        cnt_nx = '0;
        state_nx = REL;
      end
      REL: if (tick) begin
        cnt_nx = hit ? '0 : cnt + 1'b1;
        state_nx = (!hit && cnt_end) ? SCAN : REL;
      end
      default: state_nx = SCAN;
    endcase
  end
  // Scanner state, column, captured code and reported key
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SCAN;
      cnt <= '0;
      code <= '0;
      col_sel <= '0;
      key_code <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (cap) code <= cur_code;
      if (col_inc) col_sel <= col_sel + 1'b1;
      if (state_nx == PRESS) key_code <= cur_code;
    end
  // Entry shift register and register bank; commit takes the pre-shift entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      entry <= '0;
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
    end else if (commit) begin
      bank[addr_wr] <= entry;
      entry <= key_valid ? WIDTH'(key_code) : '0;
    end else if (key_valid) begin
      entry <= shifted[WIDTH-1:0];
    end
  // ALU: bit WIDTH carries carry/borrow/shifted-out bit
  always_comb begin
    alu = '0;
    case (op)
      3'd0: alu = {1'b0, a} + {1'b0, b};
      3'd1: alu = {1'b0, a} - {1'b0, b};
      3'd2: alu = {1'b0, a & b};
      3'd3: alu = {1'b0, a | b};
      3'd4: alu = {1'b0, a ^ b};
      3'd5: alu = {a, 1'b0};
      3'd6: alu = {a[0], 1'b0, a[WIDTH-1:1]};
`ifdef ALU_ACCUM_EN
      default: alu = {1'b0, result} + {1'b0, a};
`else
      default: alu = {1'b0, a};
`endif
    endcase
  end
  // Registered result and flags, held while ena is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
    end else if (ena) begin
      result <= alu[WIDTH-1:0];
      carry <= alu[WIDTH];
      zero <= alu[WIDTH-1:0] == '0;
    end
endmodule

// File: tb/tb_keypad_calc_core.sv
// tb_keypad_calc_core: random keypad/ALU stimulus against a behavioural keypad/calculator model
module tb_keypad_calc_core;
  localparam int W = 8, N = 4, SD = 4, DB = 4;
  logic clk = 0, rst_n = 0, ena = 0, commit = 0;
  logic [3:0] row_in, key_code, key = 0;
  logic [1:0] col_sel, addr_wr = 0, addr_a = 0, addr_b = 0;
  logic [2:0] op = 0;
  logic key_valid, carry, zero, key_down = 0;
  logic [W-1:0] entry, result;
  int errs = 0, checks = 0;
  int m_entry = 0, m_res = 0, m_c = 0;
  int m_bank[N];
  keypad_calc_core #(.WIDTH(W), .NREGS(N), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .row_in(row_in), .col_sel(col_sel),
    .commit(commit), .addr_wr(addr_wr), .addr_a(addr_a), .addr_b(addr_b), .op(op),
    .key_valid(key_valid), .key_code(key_code), .entry(entry), .result(result),
    .carry(carry), .zero(zero)
  );
  always #5 clk = ~clk;
  // A physical keypad: the held key shorts its row only while its column is scanned
  assign row_in = (key_down && col_sel == key[3:2]) ? 4'(1 << key[1:0]) : 4'h0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic press(input logic [3:0] k, input bit do_commit, input logic [1:0] wa);
    int n = 0, extra = 0;
    key = k;
    key_down = 1;
    while (!key_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("kv_seen", 32'(n < 400), 1);
    chk("key_code", key_code, k);
    if (do_commit) begin
      commit = 1;
      addr_wr = wa;
      m_bank[wa] = m_entry;
      m_entry = k;
    end else m_entry = (m_entry * 16 + k) % 256;
    @(negedge clk);
    commit = 0;
    chk("entry", entry, m_entry);
    repeat (30) begin
      if (key_valid) extra++;
      @(negedge clk);
    end
    chk("no_repeat", extra, 0);
    key_down = 0;
    repeat (40) @(negedge clk);
  endtask
  task automatic commit_entry(input logic [1:0] wa);
    addr_wr = wa;
    commit = 1;
    @(negedge clk);
    commit = 0;
    m_bank[wa] = m_entry;
    m_entry = 0;
    chk("entry_clr", entry, 0);
  endtask
  task automatic load(input logic [1:0] wa, input logic [7:0] v);
    press(v[7:4], 0, 0);
    press(v[3:0], 0, 0);
    commit_entry(wa);
  endtask
  task automatic alu_chk(input logic [1:0] aa, input logic [1:0] bb, input logic [2:0] o);
    int x = m_bank[aa], y = m_bank[bb], s;
    addr_a = aa;
    addr_b = bb;
    op = o;
    ena = 1;
    @(negedge clk);
    ena = 0;
    case (o)
      0: begin s = x + y; m_res = s % 256; m_c = s / 256; end
      1: begin m_res = (x - y + 256) % 256; m_c = int'(x < y); end
      2: begin m_res = x & y; m_c = 0; end
      3: begin m_res = x | y; m_c = 0; end
      4: begin m_res = x ^ y; m_c = 0; end
      5: begin m_res = (x * 2) % 256; m_c = x / 128; end
      6: begin m_res = x / 2; m_c = x % 2; end
`ifdef ALU_ACCUM_EN
      default: begin s = m_res + x; m_res = s % 256; m_c = s / 256; end
`else
      default: begin m_res = x; m_c = 0; end
`endif
    endcase
    chk($sformatf("result op%0d", o), result, m_res);
    chk($sformatf("carry op%0d", o), carry, m_c);
    chk($sformatf("zero op%0d", o), zero, int'(m_res == 0));
  endtask
  initial begin
    int extra;
    foreach (m_bank[i]) m_bank[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_col", col_sel, 0);
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("scan_col%0d", k), col_sel, k % 4);
      repeat (SD) @(negedge clk);
    end
    chk("rst_kv", key_valid, 0);
    chk("rst_kc", key_code, 0);
    chk("rst_entry", entry, 0);
    chk("rst_res", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    press(4'h6, 0, 0);
    key = 4'hB;
    while (col_sel == 2'd2) @(negedge clk);
    while (col_sel != 2'd2) @(negedge clk);
    key_down = 1;
    extra = 0;
    repeat (9) begin
      if (key_valid) extra++;
      @(negedge clk);
    end
    key_down = 0;
    repeat (3) begin
      if (key_valid) extra++;
      @(negedge clk);
    end
    chk("bounce_col", col_sel, 2);
    repeat (60) begin
      if (key_valid) extra++;
      @(negedge clk);
    end
    chk("bounce_nokv", extra, 0);
    press(4'h3, 0, 0);
    press(4'hA, 0, 0);
    commit_entry(2);
    alu_chk(2, 2, 2);
    press(4'h7, 0, 0);
    press(4'h5, 1, 3);
    alu_chk(3, 3, 3);
    load(0, 8'hF0);
    load(1, 8'h20);
    alu_chk(0, 1, 0);
    alu_chk(1, 0, 1);
    alu_chk(0, 0, 1);
    repeat (4) load(2'($urandom_range(0, 3)), 8'($urandom));
    repeat (40) alu_chk(2'($urandom), 2'($urandom), 3'($urandom));
`ifdef ALU_ACCUM_EN
    load(0, 8'h40);
    alu_chk(0, 0, 1);
    repeat (4) alu_chk(0, 0, 7);
`endif
    addr_a = 2'($urandom);
    op = 3'($urandom);
    repeat (3) @(negedge clk);
    chk("hold_res", result, m_res);
    chk("hold_carry", carry, m_c);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/keypad_calc_core.md
# keypad_calc_core

Parametrised keypad-entry calculator core: scans a 4x4 matrix keypad, debounces presses, shifts hex digits into an entry register, commits entries into an NREGS x WIDTH register bank, and drives a registered 8-op ALU with carry/zero flags. It replaces the fixed 2-bit-counter encoder / 4x8 register bank / 2-bit-op ALU path, and sits directly under the tile top, between the keypad pins and the output bus.

## Interface
- WIDTH, 8: datapath width; multiple of 4, >= 4
- NREGS, 4: register bank depth; power of 2, >= 2; AW = clog2(NREGS)
- SCAN_DIV, 16: clock cycles per scan tick; >= 2
- DEBOUNCE, 4: consecutive matching ticks required for press and for release; >= 1

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  ALU result/flag update enable
- row_in  in  4  keypad rows, active high, synchronised internally (2-flop)
- col_sel  out  2  scanned column index
- commit  in  1  one-cycle pulse: write entry register to bank[addr_wr]
- addr_wr, addr_a, addr_b  in  AW  write / read-A / read-B addresses
- op  in  3  ALU operation select
- key_valid  out  1  one-cycle pulse per debounced press
- key_code  out  4  {col_sel, row index} of last press; held until next press
- entry  out  WIDTH  current entry register
- result  out  WIDTH  registered ALU result
- carry, zero  out  1  registered flags

## Operation
- Tick: divider counts 0..SCAN_DIV-1; tick = cycle where divider == SCAN_DIV-1.
- Scanner FSM, transitions on ticks only:
  - SCAN: row_s == 0 -> col_sel++ (wraps 3->0); else capture code = {col_sel, lowest set row index}, cnt=1 -> DEB (cnt=1, DEBOUNCE=1 -> PRESS immediately).
  - DEB: same code -> cnt++; cnt reaches DEBOUNCE -> PRESS; different code or rows clear -> SCAN, col_sel unchanged.
  - PRESS: one cycle; key_valid=1, key_code updated -> REL.
  - REL: col_sel frozen; rows clear for DEBOUNCE consecutive ticks -> SCAN; any row high resets release count. Second key pressed while held is ignored.
- Entry: on key_valid, entry <= {entry[WIDTH-5:0], key_code}.
- Commit: bank[addr_wr] <= entry, entry <= 0. Commit and key_valid in same cycle: bank gets pre-shift entry; entry <= {0, key_code}.
- Reads: bank[addr_a], bank[addr_b] combinational; a same-cycle write is visible next cycle.
- ALU (A, B from bank), op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL A by 1, 6 SHR A by 1 logical, 7 PASS A.
- carry: ADD = bit WIDTH of A+B; SUB = borrow (A<B unsigned); SHL = A[WIDTH-1]; SHR = A[0]; others 0.
- zero = (next result == 0). All arithmetic modulo 2^WIDTH.

## Timing
- Reset (async assert, sync release): col_sel=0, divider=0, FSM=SCAN, key_valid=0, key_code=0, entry=0, bank all 0, result=0, carry=0, zero=0.
- result/carry/zero update on every clk with ena=1; held with ena=0. Latency 1 cycle from operand/op change.
- Press latency: 2 sync cycles + DEBOUNCE ticks; key_valid at cycle after DEBOUNCE-th matching tick.
- Reset mid-debounce or mid-release: FSM to SCAN, no key_valid emitted, partial entry lost.
- commit with ena=0 still writes the bank.

## Configuration
- ALU_ACCUM_EN defined: op 7 = ACC, result <= result + A, carry = adder carry-out; result register acts as accumulator.
- Undefined: op 7 = PASS A, carry 0.

## Test plan
- Reset, SCAN_DIV=4: col_sel cycles 0,1,2,3,0 every 4 clocks; all outputs 0.
- Hold row 2 while col_sel=1, DEBOUNCE=4, WIDTH=8 -> exactly one key_valid, key_code=4'h6, entry=8'h06; no repeat while held.
- Bounce: row toggles after 2 matching ticks -> no key_valid; FSM returns to SCAN on same column.
- Keys 3 then A, commit with addr_wr=2 -> bank[2]=8'h3A, entry=0; commit coincident with key 5 -> bank gets old entry, entry=8'h05.
- A=8'hF0, B=8'h20: ADD -> result 8'h10 carry 1; SUB B-A via swapped addresses -> 8'h30 carry 1; A=B SUB -> result 0 zero 1.
- ALU_ACCUM_EN, A=8'h40, op 7 held four cycles -> 40, 80, C0, 00 with carry 1 on last; ena=0 freezes value.
